// File: rtl/carrier_burst_gen.sv
// ----------------------------------------------------------------------------
// carrier_burst_gen
//   Carrier generator for the pulse transmitter. It produces a carrier with
//   independently programmable high and low phase lengths, so any duty cycle
//   is possible. It also supports output inversion, a programmable idle level
//   and a finite burst mode (N periods, then stop). Strobes report each
//   completed period and each completed burst to the transmit sequencer.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | out = idle_level; waits for en=1 while armed
//   HIGH  | active high phase, lasts high_duration+1 cycles
//   LOW   | active low phase, lasts low_duration+1 cycles; decides the
//         | period boundary (next period or end of burst)
//
// Ports
//   clk            system clock, rising edge
//   sys_rst_n      asynchronous active-low reset
//   en             level enable; low aborts to IDLE
//   high_duration  high phase length minus 1
//   low_duration   low phase length minus 1
//   burst_count    periods per burst, 0 = continuous
//   idle_level     out value while idle
//   invert         inverts carrier polarity during active phases
//   out            registered carrier output
//   busy           registered, high while in HIGH or LOW
//   period_done    one-cycle strobe after each completed period
//   burst_done     one-cycle strobe when a finite burst completes
// ----------------------------------------------------------------------------
module carrier_burst_gen #(
    parameter int TIMER_WIDTH = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic                   en,
    input  logic [TIMER_WIDTH-1:0] high_duration,
    input  logic [TIMER_WIDTH-1:0] low_duration,
    input  logic [COUNT_WIDTH-1:0] burst_count,
    input  logic                   idle_level,
    input  logic                   invert,
    output logic                   out,
    output logic                   busy,
    output logic                   period_done,
    output logic                   burst_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [TIMER_WIDTH-1:0] r_counter;
    logic [TIMER_WIDTH-1:0] r_lo_sh;
    logic [COUNT_WIDTH-1:0] r_bc_sh;
    logic [COUNT_WIDTH-1:0] r_period_cnt;
    logic                   r_armed;
    logic                   r_out;
    logic                   r_busy;
    logic                   r_period_done;
    logic                   r_burst_done;

    logic [COUNT_WIDTH-1:0] w_period_next;
    logic                   w_burst_end;

    // Wraps at 2^COUNT_WIDTH; only meaningful in finite burst mode.
    assign w_period_next = r_period_cnt + COUNT_WIDTH'(1);
    assign w_burst_end   = (r_bc_sh != '0) && (w_period_next == r_bc_sh);

    // The high phase length goes straight into the down-counter at every
    // period boundary, so only the low phase needs a shadow copy.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= ST_IDLE;
            r_counter     <= '0;
            r_lo_sh       <= '0;
            r_bc_sh       <= '0;
            r_period_cnt  <= '0;
            r_armed       <= 1'b1;
            r_out         <= 1'b0;
            r_busy        <= 1'b0;
            r_period_done <= 1'b0;
            r_burst_done  <= 1'b0;
        end else begin
            r_period_done <= 1'b0;
            r_burst_done  <= 1'b0;

            // A new burst needs en to have been seen low at least once.
            if (!en) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (en && r_armed) begin
                        r_bc_sh      <= burst_count;
                        r_lo_sh      <= low_duration;
                        r_period_cnt <= '0;
                        r_counter    <= high_duration;
                        r_state      <= ST_HIGH;
                        r_out        <= ~invert;
                        r_busy       <= 1'b1;
                    end else begin
                        r_out  <= idle_level;
                        r_busy <= 1'b0;
                    end
                end

                ST_HIGH: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                        r_out   <= idle_level;
                        r_busy  <= 1'b0;
                    end else if (r_counter != '0) begin
                        r_counter <= r_counter - TIMER_WIDTH'(1);
                    end else begin
                        r_state   <= ST_LOW;
                        r_counter <= r_lo_sh;
                        r_out     <= invert;
                    end
                end

                ST_LOW: begin
                    // Abort takes priority, including on the final LOW cycle.
                    if (!en) begin
                        r_state <= ST_IDLE;
                        r_out   <= idle_level;
                        r_busy  <= 1'b0;
                    end else if (r_counter != '0) begin
                        r_counter <= r_counter - TIMER_WIDTH'(1);
                    end else begin
                        r_period_done <= 1'b1;
                        if (w_burst_end) begin
                            r_state      <= ST_IDLE;
                            r_out        <= idle_level;
                            r_busy       <= 1'b0;
                            r_burst_done <= 1'b1;
                            r_armed      <= 1'b0;
                        end else begin
                            r_period_cnt <= w_period_next;
                            r_lo_sh      <= low_duration;
                            r_counter    <= high_duration;
                            r_state      <= ST_HIGH;
                            r_out        <= ~invert;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= idle_level;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out         = r_out;
    assign busy        = r_busy;
    assign period_done = r_period_done;
    assign burst_done  = r_burst_done;

endmodule

// File: tb/tb_carrier_burst_gen.sv
// ----------------------------------------------------------------------------
// tb_carrier_burst_gen
//   Directed scenarios followed by randomized traffic. The reference model
//   expands each period into a queue of phase levels (high_duration+1 ones
//   followed by low_duration+1 zeros) that it samples at the period boundary,
//   then pops one level per clock.
// ----------------------------------------------------------------------------
module tb_carrier_burst_gen;

    localparam int TW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          sys_rst_n;
    logic          en;
    logic [TW-1:0] high_duration;
    logic [TW-1:0] low_duration;
    logic [CW-1:0] burst_count;
    logic          idle_level;
    logic          invert;
    logic          out;
    logic          busy;
    logic          period_done;
    logic          burst_done;

    carrier_burst_gen #(.TIMER_WIDTH(TW), .COUNT_WIDTH(CW)) dut (
        .clk           (clk),
        .sys_rst_n     (sys_rst_n),
        .en            (en),
        .high_duration (high_duration),
        .low_duration  (low_duration),
        .burst_count   (burst_count),
        .idle_level    (idle_level),
        .invert        (invert),
        .out           (out),
        .busy          (busy),
        .period_done   (period_done),
        .burst_done    (burst_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit   m_active;
    bit   m_armed;
    bit   m_q[$];
    int   m_periods;
    int   m_bc;
    logic exp_out, exp_busy, exp_pd, exp_bd;

    // statistics for the directed scenarios
    int   st_pd, st_bd, st_busy, st_steps, st_last_pd;

    function automatic void m_load_period();
        for (int i = 0; i <= int'(high_duration); i++) m_q.push_back(1'b1);
        for (int i = 0; i <= int'(low_duration); i++)  m_q.push_back(1'b0);
    endfunction

    function automatic void m_reset();
        m_active  = 1'b0;
        m_armed   = 1'b1;
        m_q.delete();
        m_periods = 0;
        m_bc      = 0;
        exp_out   = 1'b0;
        exp_busy  = 1'b0;
        exp_pd    = 1'b0;
        exp_bd    = 1'b0;
    endfunction

    function automatic void m_edge();
        bit lvl;
        exp_pd = 1'b0;
        exp_bd = 1'b0;
        if (!m_active) begin
            if (en && m_armed) begin
                m_bc      = int'(burst_count);
                m_periods = 0;
                m_q.delete();
                m_load_period();
                lvl      = m_q.pop_front();
                exp_out  = lvl ^ invert;
                m_active = 1'b1;
            end else begin
                exp_out = idle_level;
            end
        end else if (!en) begin
            m_active = 1'b0;
            m_q.delete();
            exp_out  = idle_level;
        end else if (m_q.size() != 0) begin
            lvl     = m_q.pop_front();
            exp_out = lvl ^ invert;
        end else begin
            exp_pd = 1'b1;
            m_periods++;
            if (m_bc != 0 && m_periods == m_bc) begin
                m_active = 1'b0;
                exp_out  = idle_level;
                exp_bd   = 1'b1;
                m_armed  = 1'b0;
            end else begin
                m_load_period();
                lvl     = m_q.pop_front();
                exp_out = lvl ^ invert;
            end
        end
        if (!en) m_armed = 1'b1;
        exp_busy = m_active;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        chk("out", out, exp_out);
        chk("busy", busy, exp_busy);
        chk("period_done", period_done, exp_pd);
        chk("burst_done", burst_done, exp_bd);
        st_steps++;
        if (busy) st_busy++;
        if (burst_done) st_bd++;
        if (period_done) begin
            st_pd++;
            st_last_pd = st_steps;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_stats();
        st_pd = 0; st_bd = 0; st_busy = 0; st_steps = 0; st_last_pd = 0;
    endtask

    // Called shortly after an edge; asserts reset between edges.
    task automatic async_reset();
        #3 sys_rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_out", out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pd", period_done, 1'b0);
        chk("rst_bd", burst_done, 1'b0);
        #2 sys_rst_n = 1'b1;
    endtask

    int prev_pd;

    initial begin
        sys_rst_n     = 1'b0;
        en            = 1'b0;
        high_duration = '0;
        low_duration  = '0;
        burst_count   = '0;
        idle_level    = 1'b0;
        invert        = 1'b0;
        m_reset();
        clr_stats();
        #3;
        chk("reset_out", out, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_pd", period_done, 1'b0);
        chk("reset_bd", burst_done, 1'b0);
        #4 sys_rst_n = 1'b1;

        // first edge after release drives idle_level
        idle_level = 1'b1;
        step();
        idle_level = 1'b0;
        step();

        // 3-period burst, 3 high / 2 low
        high_duration = 16'd2;
        low_duration  = 16'd1;
        burst_count   = 8'd3;
        en            = 1'b1;
        clr_stats();
        prev_pd = 0;
        for (int i = 0; i < 17; i++) begin
            step();
            if (period_done) begin
                if (prev_pd != 0) chk("pd_spacing", st_steps - prev_pd, 5);
                prev_pd = st_steps;
            end
        end
        chk("burst_pd_count", st_pd, 3);
        chk("burst_bd_count", st_bd, 1);
        chk("burst_busy_cycles", st_busy, 15);

        // burst completed with en still high: stays idle; re-arm via en low
        steps(4);
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        chk("rearm_out", out, 1'b1);
        steps(6);

        // minimum period, continuous
        en = 1'b0;
        step();
        high_duration = '0;
        low_duration  = '0;
        burst_count   = '0;
        en = 1'b1;
        clr_stats();
        steps(20);
        chk("toggle_pd_count", st_pd, 9);
        chk("toggle_bd_count", st_bd, 0);

        // mid-HIGH duration change takes effect next period
        en = 1'b0;
        step();
        high_duration = 16'd3;
        low_duration  = 16'd3;
        en = 1'b1;
        steps(2);
        high_duration = 16'd1;
        steps(16);

        // abort during 3rd HIGH cycle with idle=1, invert=1
        en = 1'b0;
        step();
        idle_level    = 1'b1;
        invert        = 1'b1;
        high_duration = 16'd4;
        low_duration  = 16'd2;
        en = 1'b1;
        clr_stats();
        steps(3);
        en = 1'b0;
        step();
        chk("abort_out", out, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_strobes", st_pd + st_bd, 0);
        steps(2);

        // async reset mid-LOW
        idle_level    = 1'b0;
        invert        = 1'b0;
        high_duration = 16'd1;
        low_duration  = 16'd5;
        en = 1'b1;
        steps(4);
        async_reset();
        en = 1'b0;
        idle_level = 1'b1;
        step();
        chk("post_rst_out", out, 1'b1);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 4) en = ~en;
            if ($urandom_range(0, 99) < 10) high_duration = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 99) < 10) low_duration  = 16'($urandom_range(0, 5));
            if (!m_active) begin
                if ($urandom_range(0, 99) < 20) idle_level  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 99) < 20) invert      = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 99) < 20) burst_count = 8'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 999) < 3) async_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/carrier_burst_gen.md
Name: carrier_burst_gen

Overview:
- Next-generation carrier generator for the pulse transmitter.
- Produces a carrier with independently programmable high and low phase lengths, giving arbitrary duty cycle.
- Supports output inversion, a programmable idle level and a finite burst mode (N periods, then stop).
- Sits between the register file and the output mux. Provides period and burst completion strobes for the transmit sequencer.

Parameters:
TIMER_WIDTH, 16, width of high/low phase duration fields and phase counter
COUNT_WIDTH, 8, width of burst period count and period counter

Ports:
clk  input  1  system clock; all state updates on rising edge
sys_rst_n  input  1  asynchronous active-low reset
en  input  1  level enable; high = run, low = abort to idle
high_duration  input  TIMER_WIDTH  high phase length minus 1 (cycles)
low_duration  input  TIMER_WIDTH  low phase length minus 1 (cycles)
burst_count  input  COUNT_WIDTH  periods per burst; 0 = continuous
idle_level  input  1  out value while idle
invert  input  1  invert carrier polarity during active phases
out  output  1  registered carrier output
busy  output  1  registered; 1 while state is HIGH or LOW
period_done  output  1  one-cycle strobe at end of each completed period
burst_done  output  1  one-cycle strobe when a finite burst completes

Behaviour:
- Reset (sys_rst_n=0, async): state=IDLE, counters=0, shadows=0, armed=1, out=0, busy=0, period_done=0, burst_done=0.
- The first edge after reset release drives out to idle_level.
- States: IDLE, HIGH, LOW. All outputs are registered and update on the same edge as the state transition.
- IDLE:
  - out=idle_level, busy=0.
  - If en=1 and armed=1:
    - latch hi_sh=high_duration, lo_sh=low_duration, bc_sh=burst_count
    - period_cnt=0, counter=high_duration
    - go to HIGH; out=1^invert
- HIGH:
  - If counter!=0: decrement.
  - Else: go to LOW, counter=lo_sh, out=0^invert.
  - Phase lasts hi_sh+1 cycles.
- LOW:
  - If counter!=0: decrement.
  - Else: pulse period_done for the next cycle.
  - If bc_sh!=0 and period_cnt+1==bc_sh:
    - go to IDLE, out=idle_level, pulse burst_done, armed=0
  - Otherwise:
    - period_cnt+=1 (wraps at 2^COUNT_WIDTH; irrelevant when continuous)
    - re-latch hi_sh/lo_sh from the inputs
    - counter=high_duration, go to HIGH, out=1^invert
  - Phase lasts lo_sh+1 cycles.
- Duration changes mid-period take effect at the next period boundary only. burst_count is latched once per burst.
- Period length = (hi_sh+1)+(lo_sh+1) cycles. Minimum is 2 (both zero): out toggles every cycle.
- Max values: all-ones durations give 2^TIMER_WIDTH cycles per phase, with no overflow.
- en=0 in HIGH or LOW:
  - abort on the next edge: IDLE, out=idle_level, busy=0
  - no period_done or burst_done for the partial period
- armed:
  - cleared on burst completion
  - set whenever en=0 is sampled
  - A new burst therefore needs en low for at least 1 cycle.
  - Continuous mode never clears armed.
- Simultaneous cases:
  - en falling on the final LOW cycle: abort wins, no strobes.
  - invert/idle_level are not latched. Changes act on the next out update only; they do not force an extra transition.
- Async reset mid-burst: immediate return to the reset values above.

Test Plan:
- Reset, then en=1, high=2, low=1, burst=3, invert=0, idle=0 -> out pattern 1,1,1,0,0 repeated 3 times. period_done strobes 3 times, 5 cycles apart. burst_done asserted once, with out=0 the cycle after the last low cycle. busy high for 15 cycles.
- high=0, low=0, burst=0, en held high 20 cycles -> out toggles every cycle starting at 1. period_done every 2 cycles. burst_done never asserted.
- Continuous run high=3, low=3; change high_duration to 1 mid-HIGH -> current period stays 4/4; next period is 2 high / 4 low.
- Burst completes with en still high -> stays IDLE, out=idle_level. Drop en 1 cycle, raise again -> new burst starts, out=1 one edge later.
- idle=1, invert=1, high=4, low=2; drop en during 3rd cycle of HIGH -> out=1 next edge, busy=0, no period_done or burst_done.
- Assert sys_rst_n=0 asynchronously mid-LOW (between edges) -> out, busy and strobes go 0 immediately. After release, out=idle_level on the first edge.
